uart_rx_frame_ctrl: RTL

Frame controller that sequences the byte stream from the UART receiver (its data_out/rx_done outputs) into validated packets.
- Frame format: SOF byte, LEN byte, LEN payload bytes, CHK byte.
- Payload is buffered internally and released downstream on a valid/ready stream only after the checksum passes.
- Reports per-frame success/error pulses with an error code.
- Sits between uart_rx and the command decoder / application logic.

---
 rtl/uart_rx_frame_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller: turns uart_rx bytes (SOF, LEN, payload, CHK) into checksum-validated payload streams.
// Optional per-frame statistics counters are built when UART_FRAME_STATS_EN is defined.
module uart_rx_frame_ctrl #(
    parameter int         CLK_FREQ     = 12_000_000,
    parameter int         BAUD_RATE    = 9_600,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SOF_BYTE     = 8'hAA,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [15:0] ok_count,
    output logic [15:0] err_count
);

    localparam int CLK_PER_BIT  = CLK_FREQ / BAUD_RATE;
    localparam int TIMEOUT_CLKS = CLK_PER_BIT * TIMEOUT_BITS;
    localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam int PW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [8:0]    MAX_LEN9 = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN, S_ERR
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      len;
    logic [7:0]      sum;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TW-1:0]   to_cnt;
    logic            ok_pulse;
    logic [1:0]      err_code_r, code_nx;
    logic            timeout, last_wr, last_rd, counting;
    logic [7:0]      buf_mem [MAX_LEN];

    assign timeout  = (to_cnt == TO_LAST) && !rx_valid;
    assign last_wr  = (8'(wr_ptr) == len - 8'd1);
    assign last_rd  = (8'(rd_ptr) == len - 8'd1);
    assign counting = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);

    always_comb begin
        state_nx = state;
        code_nx  = err_code_r;
        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == SOF_BYTE) state_nx = S_LEN;
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || {1'b0, rx_data} > MAX_LEN9) begin
                        state_nx = S_ERR;
                        code_nx  = 2'b01;
                    end else begin
                        state_nx = S_PAYLOAD;
                    end
                end else if (timeout) begin
                    state_nx = S_ERR;
                    code_nx  = 2'b11;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    if (last_wr) state_nx = S_CHK;
                end else if (timeout) begin
                    state_nx = S_ERR;
                    code_nx  = 2'b11;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == sum) begin
                        state_nx = S_DRAIN;
                    end else begin
                        state_nx = S_ERR;
                        code_nx  = 2'b10;
                    end
                end else if (timeout) begin
                    state_nx = S_ERR;
                    code_nx  = 2'b11;
                end
            end
            S_DRAIN: begin
                if (out_ready && last_rd) state_nx = S_IDLE;
            end
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The timeout counter runs only while a frame is being received; any byte restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            err_code_r <= 2'b00;
            ok_pulse   <= 1'b0;
            to_cnt     <= '0;
            len        <= 8'd0;
            sum        <= 8'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= state_nx;
            err_code_r <= code_nx;
            ok_pulse   <= (state == S_CHK) && (state_nx == S_DRAIN);
            if (rx_valid || !counting) to_cnt <= '0;
            else                       to_cnt <= to_cnt + TW'(1);
            if (state == S_LEN && state_nx == S_PAYLOAD) begin
                len    <= rx_data;
                sum    <= rx_data;
                wr_ptr <= '0;
            end
            if (state == S_PAYLOAD && rx_valid) begin
                sum    <= sum + rx_data;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (state == S_CHK && state_nx == S_DRAIN) rd_ptr <= '0;
            if (state == S_DRAIN && out_ready)         rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == S_PAYLOAD && rx_valid) buf_mem[wr_ptr] <= rx_data;
    end

    assign out_valid = (state == S_DRAIN);
    assign out_data  = out_valid ? buf_mem[rd_ptr] : 8'h00;
    assign out_last  = out_valid && last_rd;
    assign frame_ok  = ok_pulse;
    assign frame_err = (state == S_ERR);
    assign err_code  = err_code_r;
    assign busy      = (state != S_IDLE);

`ifdef UART_FRAME_STATS_EN
    logic [15:0] ok_cnt, err_cnt;

    // Saturating so a long-running link never wraps back to a misleadingly small count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ok_cnt  <= 16'h0000;
            err_cnt <= 16'h0000;
        end else begin
            if (ok_pulse && ok_cnt != 16'hFFFF)   ok_cnt  <= ok_cnt + 16'd1;
            if (frame_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign ok_count  = ok_cnt;
    assign err_count = err_cnt;
`else
    assign ok_count  = 16'h0000;
    assign err_count = 16'h0000;
`endif

endmodule
